field_gather: RTL and testbench

- Gather-direction counterpart of the charge scatter: for each gyropoint, reads the four surrounding grid-node field values, weights them bilinearly by the fractional position, and emits one interpolated field sample per particle.
- Sits between the particle pusher (source of gyropoints) and the grid field RAM (fixed-latency read port), feeding the force/push stage.

---
 rtl/field_gather.sv | 261 ++++++++++++++++++++++++++
 tb/tb_field_gather.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/field_gather.sv
// field_gather: bilinear gather of the four grid-node field values around each gyropoint.
// Fixed-latency field RAM read, multiply/sum/round pipeline and a credited output FIFO.
module field_gather #(
    parameter int GRID_BITS  = 6,
    parameter int FIELD_W    = 18,
    parameter int TAG_W      = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [GRID_BITS-1:0]              x_whole,
    input  logic [GRID_BITS-1:0]              y_whole,
    input  logic [11:0]                       x_frac,
    input  logic [11:0]                       y_frac,
    input  logic [TAG_W-1:0]                  tag_in,
    output logic                              rd_en_out,
    output logic [3:0][2*GRID_BITS-1:0]       raddr_out,
    input  logic [3:0][FIELD_W-1:0]           rdata_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [FIELD_W-1:0]         field_out,
    output logic [TAG_W-1:0]                  tag_out
);

    localparam int AW  = 2 * GRID_BITS;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR = $clog2(FIFO_DEPTH);
    localparam int PW  = FIELD_W + 27;
    localparam int SW  = FIELD_W + 29;

    localparam logic [CW-1:0]        DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic signed [SW-1:0] HALF      = {{(SW-24){1'b0}}, 1'b1, 23'd0};

    // ---------------- credit / accept ----------------
    logic              r_run;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_count;
    logic [CW:0]       w_occ;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    // Occupancy counts every result already promised a FIFO slot, so a push can never overflow.
    assign w_occ    = {1'b0, r_inflight} + {1'b0, r_count};
    assign in_ready = r_run && (w_occ < {1'b0, DEPTH_CNT});
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_inflight <= '0;
        end else begin
            r_run <= 1'b1;
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ---------------- stage A: addresses, weights ----------------
    logic [GRID_BITS-1:0] w_x1;
    logic [GRID_BITS-1:0] w_y1;
    logic [12:0]          w_inv_x;
    logic [12:0]          w_inv_y;
    logic [12:0]          w_fx;
    logic [12:0]          w_fy;
    logic [3:0][25:0]     w_wt;

    assign w_x1    = x_whole + GRID_BITS'(1);
    assign w_y1    = y_whole + GRID_BITS'(1);
    assign w_fx    = {1'b0, x_frac};
    assign w_fy    = {1'b0, y_frac};
    assign w_inv_x = 13'd4096 - w_fx;
    assign w_inv_y = 13'd4096 - w_fy;
    assign w_wt[0] = w_inv_y * w_inv_x;
    assign w_wt[1] = w_inv_y * w_fx;
    assign w_wt[2] = w_fy * w_inv_x;
    assign w_wt[3] = w_fy * w_fx;

    logic                  r_a_valid;
    logic [3:0][AW-1:0]    r_raddr;
    logic [3:0][25:0]      r_a_w;
    logic [TAG_W-1:0]      r_a_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid <= 1'b0;
            r_raddr   <= '0;
            r_a_w     <= '0;
            r_a_tag   <= '0;
        end else begin
            r_a_valid <= w_accept;
            if (w_accept) begin
                r_raddr[0] <= {y_whole, x_whole};
                r_raddr[1] <= {y_whole, w_x1};
                r_raddr[2] <= {w_y1, x_whole};
                r_raddr[3] <= {w_y1, w_x1};
                r_a_w      <= w_wt;
                r_a_tag    <= tag_in;
            end
        end
    end

    assign rd_en_out = r_a_valid;
    assign raddr_out = r_raddr;

    // ---------------- read-latency delay line ----------------
    logic [RD_LAT-1:0]     r_d_valid;
    logic [3:0][25:0]      r_d_w   [RD_LAT];
    logic [TAG_W-1:0]      r_d_tag [RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_valid <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_d_w[k]   <= '0;
                r_d_tag[k] <= '0;
            end
        end else begin
            r_d_valid[0] <= r_a_valid;
            r_d_w[0]     <= r_a_w;
            r_d_tag[0]   <= r_a_tag;
            for (int k = 1; k < RD_LAT; k++) begin
                r_d_valid[k] <= r_d_valid[k-1];
                r_d_w[k]     <= r_d_w[k-1];
                r_d_tag[k]   <= r_d_tag[k-1];
            end
        end
    end

    // ---------------- stage M / S / R ----------------
    logic signed [PW-1:0] w_prod [4];
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] w_rounded;
    logic                 w_unused_bits;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_prod[i] = PW'($signed({1'b0, r_d_w[RD_LAT-1][i]})) * PW'($signed(rdata_in[i]));
        end
    end

    logic                 r_m_valid;
    logic signed [PW-1:0] r_m_p [4];
    logic [TAG_W-1:0]     r_m_tag;
    logic                 r_s_valid;
    logic signed [SW-1:0] r_s_sum;
    logic [TAG_W-1:0]     r_s_tag;
    logic                 r_r_valid;
    logic [FIELD_W-1:0]   r_r_field;
    logic [TAG_W-1:0]     r_r_tag;

    assign w_sum     = SW'(r_m_p[0]) + SW'(r_m_p[1]) + SW'(r_m_p[2]) + SW'(r_m_p[3]);
    assign w_rounded = r_s_sum + HALF;
    // Slicing above bit 24 equals the arithmetic shift; the weights sum to 2^24 so the result fits.
    assign w_unused_bits = ^{w_rounded[23:0], w_rounded[SW-1:24+FIELD_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_m_p[i] <= '0;
            r_m_tag   <= '0;
            r_s_valid <= 1'b0;
            r_s_sum   <= '0;
            r_s_tag   <= '0;
            r_r_valid <= 1'b0;
            r_r_field <= '0;
            r_r_tag   <= '0;
        end else begin
            r_m_valid <= r_d_valid[RD_LAT-1];
            for (int i = 0; i < 4; i++) r_m_p[i] <= w_prod[i];
            r_m_tag   <= r_d_tag[RD_LAT-1];
            r_s_valid <= r_m_valid;
            r_s_sum   <= w_sum;
            r_s_tag   <= r_m_tag;
            r_r_valid <= r_s_valid;
            r_r_field <= w_rounded[24 +: FIELD_W];
            r_r_tag   <= r_s_tag;
        end
    end

    // ---------------- output FIFO: registered head plus body ----------------
    logic                 r_head_v;
    logic [FIELD_W-1:0]   r_head_field;
    logic [TAG_W-1:0]     r_head_tag;
    logic [FIELD_W-1:0]   r_mem_field [FIFO_DEPTH];
    logic [TAG_W-1:0]     r_mem_tag   [FIFO_DEPTH];
    logic [PTR-1:0]       r_wp;
    logic [PTR-1:0]       r_rp;
    logic [CW-1:0]        r_body_cnt;
    logic                 w_head_load;
    logic                 w_body_any;
    logic                 w_body_pop;
    logic                 w_body_push;

    assign w_push      = r_r_valid;
    assign w_pop       = r_head_v && out_ready;
    assign w_head_load = !r_head_v || w_pop;
    assign w_body_any  = (r_body_cnt != '0);
    assign w_body_pop  = w_head_load && w_body_any;
    // A push bypasses the body only when the head is free and nothing older is waiting.
    assign w_body_push = w_push && !(w_head_load && !w_body_any);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_v     <= 1'b0;
            r_head_field <= '0;
            r_head_tag   <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_body_cnt   <= '0;
            r_count      <= '0;
        end else begin
            if (w_head_load) begin
                if (w_body_any) begin
                    r_head_v     <= 1'b1;
                    r_head_field <= r_mem_field[r_rp];
                    r_head_tag   <= r_mem_tag[r_rp];
                end else if (w_push) begin
                    r_head_v     <= 1'b1;
                    r_head_field <= r_r_field;
                    r_head_tag   <= r_r_tag;
                end else begin
                    r_head_v <= 1'b0;
                end
            end
            if (w_body_pop)  r_rp <= r_rp + PTR'(1);
            if (w_body_push) r_wp <= r_wp + PTR'(1);
            case ({w_body_push, w_body_pop})
                2'b10:   r_body_cnt <= r_body_cnt + CW'(1);
                2'b01:   r_body_cnt <= r_body_cnt - CW'(1);
                default: r_body_cnt <= r_body_cnt;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_body_push) begin
            r_mem_field[r_wp] <= r_r_field;
            r_mem_tag[r_wp]   <= r_r_tag;
        end
    end

    assign out_valid = r_head_v;
    assign field_out = r_head_field;
    assign tag_out   = r_head_tag;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && !w_pop && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_field_gather.sv
// Directed bench for field_gather: models the 2-cycle field RAM and checks interpolation,
// addressing, latency, credit back-pressure, ordering and reset flush.
module tb_field_gather;

    localparam int GB    = 6;
    localparam int FW    = 18;
    localparam int TW    = 16;
    localparam int DEPTH = 4;
    localparam int W     = TW + FW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [GB-1:0]          x_whole = '0;
    logic [GB-1:0]          y_whole = '0;
    logic [11:0]            x_frac = '0;
    logic [11:0]            y_frac = '0;
    logic [TW-1:0]          tag_in = '0;
    logic                   rd_en_out;
    logic [3:0][2*GB-1:0]   raddr_out;
    logic [3:0][FW-1:0]     rdata_in = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic signed [FW-1:0]   field_out;
    logic [TW-1:0]          tag_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    field_gather #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_whole(x_whole), .y_whole(y_whole), .x_frac(x_frac), .y_frac(y_frac),
        .tag_in(tag_in), .rd_en_out(rd_en_out), .raddr_out(raddr_out), .rdata_in(rdata_in),
        .out_valid(out_valid), .out_ready(out_ready), .field_out(field_out), .tag_out(tag_out)
    );

    // ---------------- clock and field RAM model (read latency 2) ----------------
    always #5 clk = ~clk;

    logic signed [FW-1:0] mem [0:4095];
    logic [3:0][11:0]     a1 = '0;

    always @(posedge clk) begin
        a1 <= raddr_out;
        for (int i = 0; i < 4; i++) rdata_in[i] <= mem[a1[i]];
    end

    // ---------------- driver tasks ----------------
    task automatic set_item(input logic [5:0] x, input logic [5:0] y,
                            input logic [11:0] xf, input logic [11:0] yf, input logic [15:0] tg);
        x_whole = x; y_whole = y; x_frac = xf; y_frac = yf; tag_in = tg;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends one gyropoint with out_ready=1 and reports what the DUT did with it.
    task automatic send_one(input logic [5:0] x, input logic [5:0] y,
                            input logic [11:0] xf, input logic [11:0] yf, input logic [15:0] tg,
                            output int lat, output int pulses, output logic [3:0][11:0] addr,
                            output logic signed [FW-1:0] fld, output logic [TW-1:0] tgo);
        int wt;
        set_item(x, y, xf, yf, tg);
        in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 50) begin
            @(posedge clk); #1;
            wt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        pulses = rd_en_out ? 1 : 0;
        addr   = raddr_out;
        lat    = -1;
        fld    = '0;
        tgo    = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rd_en_out) pulses++;
            if (out_valid) begin
                lat = k; fld = field_out; tgo = tag_out;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        idle(2);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b expected 0", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else n_pass++;
        n_checks++;
        if (rd_en_out !== 1'b0) $display("FAIL reset_rd_en: got %0b expected 0", rd_en_out); else n_pass++;
        n_checks++;
        if (raddr_out !== '0) $display("FAIL reset_raddr: got %h expected 0", raddr_out); else n_pass++;
        n_checks++;
        if (field_out !== '0 || tag_out !== '0)
            $display("FAIL reset_field_tag: got %0d/%h expected 0/0", field_out, tag_out);
        else n_pass++;
        rst = 1'b1;
        idle(2);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %0b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic;
        int lat, pulses;
        logic [3:0][11:0] addr;
        logic signed [FW-1:0] fld;
        logic [TW-1:0] tgo;
        mem[323] = 18'sd1234; mem[324] = 18'sd7; mem[387] = 18'sd7; mem[388] = 18'sd7;
        send_one(6'd3, 6'd5, 12'h000, 12'h000, 16'h1111, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (fld !== 18'sd1234) $display("FAIL basic_field: got %0d expected 1234", fld); else n_pass++;
        n_checks++;
        if (tgo !== 16'h1111) $display("FAIL basic_tag: got %h expected 1111", tgo); else n_pass++;
        n_checks++;
        if (pulses !== 1) $display("FAIL basic_rd_pulses: got %0d expected 1", pulses); else n_pass++;
        n_checks++;
        if (lat !== 6) $display("FAIL basic_latency: got %0d expected 6", lat); else n_pass++;
        n_checks++;
        if (addr[0] !== 12'd323 || addr[1] !== 12'd324 || addr[2] !== 12'd387 || addr[3] !== 12'd388)
            $display("FAIL basic_raddr: got %0d %0d %0d %0d expected 323 324 387 388",
                     addr[0], addr[1], addr[2], addr[3]);
        else n_pass++;
    endtask

    task automatic test_interp;
        int lat, pulses;
        logic [3:0][11:0] addr;
        logic signed [FW-1:0] fld;
        logic [TW-1:0] tgo;
        // half-way in x: (100+300)/2
        mem[650] = 18'sd100; mem[651] = 18'sd300; mem[714] = 18'sd999; mem[715] = -18'sd999;
        send_one(6'd10, 6'd10, 12'h800, 12'h000, 16'h2001, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (fld !== 18'sd200 || tgo !== 16'h2001)
            $display("FAIL interp_half_x: got %0d/%h expected 200/2001", fld, tgo);
        else n_pass++;
        // centre of cell: mean of 0,100,200,300
        mem[788] = 18'sd0; mem[789] = 18'sd100; mem[852] = 18'sd200; mem[853] = 18'sd300;
        send_one(6'd20, 6'd12, 12'h800, 12'h800, 16'h2002, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (fld !== 18'sd150) $display("FAIL interp_centre: got %0d expected 150", fld); else n_pass++;
        // -2.5 rounds half up to -2
        mem[158] = -18'sd3; mem[159] = -18'sd2; mem[222] = -18'sd2; mem[223] = -18'sd2;
        send_one(6'd30, 6'd2, 12'h800, 12'h000, 16'h2003, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (fld !== -18'sd2) $display("FAIL interp_neg_round: got %0d expected -2", fld); else n_pass++;
        // wrap corner, x_frac=0.25 y_frac=0.75: 187.5-62.5+22.5+15 = 162.5 -> 163
        mem[4095] = 18'sd1000; mem[4032] = -18'sd1000; mem[63] = 18'sd40; mem[0] = 18'sd80;
        send_one(6'd63, 6'd63, 12'h400, 12'hC00, 16'h2004, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (addr[0] !== 12'd4095 || addr[1] !== 12'd4032 || addr[2] !== 12'd63 || addr[3] !== 12'd0)
            $display("FAIL wrap_raddr: got %0d %0d %0d %0d expected 4095 4032 63 0",
                     addr[0], addr[1], addr[2], addr[3]);
        else n_pass++;
        n_checks++;
        if (fld !== 18'sd163) $display("FAIL wrap_field: got %0d expected 163", fld); else n_pass++;
        n_checks++;
        if (lat !== 6) $display("FAIL wrap_latency: got %0d expected 6", lat); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int got;
        logic [W-1:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) mem[2560 + k] = 18'(560 + 11 * k);
        got = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    int wt;
                    set_item(6'(k), 6'd40, 12'h000, 12'h000, 16'(16'h0200 + k));
                    exp_q.push_back({16'(16'h0200 + k), 18'(560 + 11 * k)});
                    in_valid = 1'b1;
                    wt = 0;
                    while (!in_ready && wt < 50) begin
                        @(posedge clk); #1;
                        wt++;
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk); #1;
                    if (out_valid) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL b2b_extra_output: got %0d/%h expected none", field_out, tag_out);
                        end else begin
                            e = exp_q.pop_front();
                            if ({tag_out, field_out} !== e)
                                $display("FAIL b2b_item%0d: got %h/%0d expected %h/%0d", got,
                                         tag_out, field_out, e[W-1:FW], $signed(e[FW-1:0]));
                            else n_pass++;
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++;
        if (got !== 6) $display("FAIL b2b_count: got %0d expected 6", got); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_fifo_full;
        int idx, acc, got;
        logic ok, ready_checked;
        logic signed [FW-1:0] first_field;
        logic [W-1:0] e;
        for (int k = 0; k < 6; k++) mem[3200 + k] = 18'(-100 * k - 1);
        out_ready = 1'b0;
        idx = 0; acc = 0;
        set_item(6'd0, 6'd50, 12'h000, 12'h000, 16'h0300);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            if (ok) begin
                exp_q.push_back({16'(16'h0300 + idx), 18'(-100 * idx - 1)});
                acc++; idx++;
                if (idx < 6) set_item(6'(idx), 6'd50, 12'h000, 12'h000, 16'(16'h0300 + idx));
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc !== 4) $display("FAIL full_accepted: got %0d expected 4", acc); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b expected 0", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1 || field_out !== -18'sd1 || tag_out !== 16'h0300)
            $display("FAIL full_head: got %0b/%0d/%h expected 1/-1/0300", out_valid, field_out, tag_out);
        else n_pass++;
        first_field = field_out;
        idle(3);
        n_checks++;
        if (field_out !== -18'sd1 || tag_out !== 16'h0300)
            $display("FAIL full_head_hold: got %0d/%h expected -1/0300", field_out, tag_out);
        else n_pass++;
        out_ready = 1'b1;
        got = 0; ready_checked = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL full_extra_output: got %0d/%h expected none", field_out, tag_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({tag_out, field_out} !== e)
                        $display("FAIL full_item%0d: got %h/%0d expected %h/%0d", got,
                                 tag_out, field_out, e[W-1:FW], $signed(e[FW-1:0]));
                    else n_pass++;
                end
                got++;
            end
            @(posedge clk); #1;
            if (got == 1 && !ready_checked) begin
                ready_checked = 1'b1;
                n_checks++;
                if (in_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %0b expected 1", in_ready);
                else n_pass++;
            end
        end
        n_checks++;
        if (got !== 4) $display("FAIL full_drain_count: got %0d expected 4 (first %0d)", got, first_field);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_flush;
        int stale, lat, pulses;
        logic [3:0][11:0] addr;
        logic signed [FW-1:0] fld;
        logic [TW-1:0] tgo;
        idle(3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_item(6'(k), 6'd60, 12'h000, 12'h000, 16'(16'h0400 + k));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || rd_en_out !== 1'b0)
            $display("FAIL flush_in_reset: got ready=%0b valid=%0b rd=%0b expected 0 0 0",
                     in_ready, out_valid, rd_en_out);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) $display("FAIL flush_stale_outputs: got %0d expected 0", stale); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL flush_ready: got %0b expected 1", in_ready); else n_pass++;
        mem[3911] = 18'sd4321;
        send_one(6'd7, 6'd61, 12'h000, 12'h000, 16'h04AA, lat, pulses, addr, fld, tgo);
        n_checks++;
        if (lat !== 6 || fld !== 18'sd4321 || tgo !== 16'h04AA)
            $display("FAIL flush_next_item: got lat=%0d %0d/%h expected 6 4321/04aa", lat, fld, tgo);
        else n_pass++;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = '0;
        test_reset;
        test_basic;
        test_interp;
        idle(2);
        test_back_to_back;
        idle(4);
        test_fifo_full;
        test_reset_flush;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
